// File: rtl/time_pkg.sv
// time_pkg: constants, field widths and FSM state type shared by the
// time-of-day counter and its digit counters.
package time_pkg;

    localparam int HOURS_MAX = 23;
    localparam int MIN_MAX   = 59;
    localparam int SEC_MAX   = 59;

    localparam int HOURS_W   = 5;
    localparam int MIN_W     = 6;
    localparam int SEC_W     = 6;

    typedef enum logic {
        UNSET = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/time_keeper_mod_counter.sv
// mod_counter: modulo-(MAX+1) counter with synchronous load.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   load_i        : load load_val_i (wins over en_i)
//   load_val_i    : value to load
//   en_i          : increment enable
//   count_o       : registered count
//   carry_o       : en_i && count_o == MAX (combinational, feeds next stage)
module mod_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         carry_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign carry_o = en_i && (count_q == W'(MAX));

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (en_i)
            count_d = carry_o ? '0 : count_q + W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/time_keeper.sv
// time_keeper: hh:mm:ss time-of-day counter loaded from the UART time-set
// receiver and advanced by a prescaled one-second tick.
//
// Build option: define TIME_KEEPER_ALARM_EN to add the sticky go-home alarm
// (alarm_ack input, alarm_o output).
//
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   load           : set-time strobe, sampled every cycle
//   ore, minute    : hours / minutes to load
//   hours_o, minutes_o, seconds_o : current time
//   time_valid     : a legal load has been accepted
//   sec_tick       : one-cycle pulse on each seconds increment
//   day_wrap       : one-cycle pulse on 23:59:59 -> 00:00:00
//   load_err       : one-cycle pulse after an out-of-range load
//   alarm_ack      : clears alarm_o (alarm build)
//   alarm_o        : sticky alarm at ALARM_H:ALARM_M:00 (alarm build)
module time_keeper
    import time_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int ALARM_H       = 17,
    parameter int ALARM_M       = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [HOURS_W-1:0] ore,
    input  logic [MIN_W-1:0]   minute,
    output logic [HOURS_W-1:0] hours_o,
    output logic [MIN_W-1:0]   minutes_o,
    output logic [SEC_W-1:0]   seconds_o,
    output logic               time_valid,
    output logic               sec_tick,
    output logic               day_wrap,
    output logic               load_err
`ifdef TIME_KEEPER_ALARM_EN
    ,
    input  logic               alarm_ack,
    output logic               alarm_o
`endif
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(TICKS_PER_SEC - 1);

    // Elaboration-time parameter sanity checks.
    if (TICKS_PER_SEC < 2) begin : g_bad_tps
        $error("TICKS_PER_SEC must be >= 2");
    end
    if (ALARM_H < 0 || ALARM_H > HOURS_MAX || ALARM_M < 0 || ALARM_M > MIN_MAX) begin : g_bad_alarm
        $error("ALARM_H/ALARM_M out of range");
    end

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic          time_valid_q;
    logic          sec_tick_q;
    logic          day_wrap_q;
    logic          load_err_q;

    logic legal_load;
    logic term_cnt;
    logic tick_d;
    logic sec_carry, min_carry, hr_carry;

    assign legal_load = load && (ore <= HOURS_W'(HOURS_MAX)) && (minute <= MIN_W'(MIN_MAX));
    assign term_cnt   = (state_q == RUN) && (presc_q == PRESC_TC);
    // A load on the terminal count restarts the second, so no tick.
    assign tick_d     = term_cnt && !legal_load;

    mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clock      (clock),
        .reset      (reset),
        .load_i     (legal_load),
        .load_val_i ('0),
        .en_i       (tick_d),
        .count_o    (seconds_o),
        .carry_o    (sec_carry)
    );

    mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clock      (clock),
        .reset      (reset),
        .load_i     (legal_load),
        .load_val_i (minute),
        .en_i       (sec_carry),
        .count_o    (minutes_o),
        .carry_o    (min_carry)
    );

    mod_counter #(.W(HOURS_W), .MAX(HOURS_MAX)) u_hr (
        .clock      (clock),
        .reset      (reset),
        .load_i     (legal_load),
        .load_val_i (ore),
        .en_i       (min_carry),
        .count_o    (hours_o),
        .carry_o    (hr_carry)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= UNSET;
            presc_q      <= '0;
            time_valid_q <= 1'b0;
            sec_tick_q   <= 1'b0;
            day_wrap_q   <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            sec_tick_q <= tick_d;
            day_wrap_q <= hr_carry;
            load_err_q <= load && !legal_load;
            if (legal_load) begin
                state_q      <= RUN;
                presc_q      <= '0;
                time_valid_q <= 1'b1;
            end else begin
                case (state_q)
                    UNSET:   presc_q <= '0;
                    RUN:     presc_q <= term_cnt ? '0 : presc_q + PW'(1);
                    default: presc_q <= '0;
                endcase
            end
        end
    end

    assign time_valid = time_valid_q;
    assign sec_tick   = sec_tick_q;
    assign day_wrap   = day_wrap_q;
    assign load_err   = load_err_q;

`ifdef TIME_KEEPER_ALARM_EN
    logic               alarm_q;
    logic               alarm_set;
    logic [MIN_W-1:0]   nxt_min;
    logic [HOURS_W-1:0] nxt_hr;

    // Time the counters will show after a seconds rollover this cycle.
    assign nxt_min = min_carry ? '0 : minutes_o + MIN_W'(1);
    assign nxt_hr  = hr_carry  ? '0 : (min_carry ? hours_o + HOURS_W'(1) : hours_o);

    assign alarm_set =
        (sec_carry && nxt_min == MIN_W'(ALARM_M) && nxt_hr == HOURS_W'(ALARM_H)) ||
        (legal_load && ore == HOURS_W'(ALARM_H) && minute == MIN_W'(ALARM_M));

    always_ff @(posedge clock) begin
        if (reset)
            alarm_q <= 1'b0;
        else if (alarm_set)
            alarm_q <= 1'b1;
        else if (alarm_ack || legal_load)
            alarm_q <= 1'b0;
    end

    assign alarm_o = alarm_q;
`endif

endmodule
